// File: rtl/seq_scheduler_pkg.sv
// Shared types and widths for the sequence scheduler and its round-robin arbiter.
package seq_scheduler_pkg;
  localparam int SCHED_NREQ  = 5;
  localparam int SCHED_SEQ_W = 32;
  localparam int ID_W        = 3;
  localparam int LAST_W      = 2;
  localparam int HITS_W      = 6;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    TAIL,
    DONE
  } state_e;
endpackage

// File: rtl/seq_scheduler_rr.sv
// Round-robin arbiter: one-hot grant to the first requester after last_grant.
module rr_arbiter
  import seq_scheduler_pkg::*;
#(
  parameter int NREQ  = SCHED_NREQ,
  parameter int IDX_W = ID_W
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NREQ-1:0]  grant
);

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    // Walk priority offsets 1..NREQ; constant indices keep the select logic flat.
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (((int'(last_grant) + off) % NREQ) == i)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_scheduler.sv
// Accepts one job at a time from NREQ requesters, streams its sequence MSB-first
// into a shared pattern FSM and reports how many samples hit, plus the last one.
module seq_scheduler
  import seq_scheduler_pkg::*;
#(
  parameter int NREQ  = SCHED_NREQ,
  parameter int SEQ_W = SCHED_SEQ_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*SEQ_W-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  flush,
  output logic                  ser_inp,
  output logic                  ser_rst,
  input  logic [LAST_W-1:0]     ser_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ID_W-1:0]       res_id,
  output logic [LAST_W-1:0]     res_last,
  output logic [HITS_W-1:0]     res_hits
);

  localparam int CNT_W = $clog2(SEQ_W + 1);

  state_e            state, nstate;
  logic [ID_W-1:0]   last_grant;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   gnt_idx;
  logic [SEQ_W-1:0]  sel_data;
  logic [SEQ_W-1:0]  shreg;
  logic [CNT_W-1:0]  bcnt;
  logic              accept;

  function automatic logic [HITS_W-1:0] hits_inc(input logic [HITS_W-1:0] h,
                                                 input logic [LAST_W-1:0] s);
    if ((s != '0) && (h != '1)) return h + HITS_W'(1);
    return h;
  endfunction

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    gnt_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_idx  = ID_W'(i);
        sel_data = req_data[i*SEQ_W +: SEQ_W];
      end
    end
  end

  // Grants are only offered from IDLE; reset and flush both hold them off.
  assign req_ready = (rst && (state == IDLE) && !flush) ? grant : '0;
  assign accept    = |(req_ready & req_valid);
  assign ser_rst   = (state == IDLE) || (state == CLR);
  assign ser_inp   = (state == STREAM) && shreg[SEQ_W-1];
  assign res_valid = (state == DONE);

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (accept) nstate = CLR;
      CLR:     nstate = STREAM;
      STREAM:  if (bcnt == CNT_W'(SEQ_W - 1)) nstate = TAIL;
      TAIL:    nstate = DONE;
      DONE:    if (res_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
    if (flush) nstate = IDLE;
  end

  // Sample ser_out one cycle behind each driven bit: STREAM cycles 2..SEQ_W, then TAIL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NREQ - 1);
      res_id     <= '0;
      res_last   <= '0;
      res_hits   <= '0;
      bcnt       <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        last_grant <= gnt_idx;
        res_id     <= gnt_idx;
        res_last   <= '0;
        res_hits   <= '0;
        bcnt       <= '0;
      end else if (state == STREAM) begin
        bcnt <= bcnt + CNT_W'(1);
        if (bcnt != '0) res_hits <= hits_inc(res_hits, ser_out);
      end else if (state == TAIL) begin
        res_hits <= hits_inc(res_hits, ser_out);
        res_last <= ser_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) shreg <= sel_data;
    else if (state == STREAM) shreg <= shreg << 1;
  end

endmodule
